// File: rtl/onehot5_seq.sv
// rtl/onehot5_seq.sv - five-state one-hot LOAD/RUN/DRAIN job sequencer with dwell counter
module onehot5_seq #(
    parameter int LOAD_CYC  = 3,
    parameter int RUN_CYC   = 8,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] state,
    output logic [4:0] nxt_state,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_RUN   = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } state_t;

    // Dwell counts are loaded as N-1 so that the phase ends when the counter reads zero.
    localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_INIT   = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             illegal;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Next-state and next-count decode; any pattern that is not exactly one hot falls to default.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        illegal   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_state = ST_LOAD;
                    nxt_cnt   = LOAD_INIT;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    nxt_state = ST_DRAIN;
                    nxt_cnt   = DRAIN_INIT;
                end else if (cnt_zero) begin
                    nxt_state = ST_RUN;
                    nxt_cnt   = RUN_INIT;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (abort || cnt_zero) begin
                    nxt_state = ST_DRAIN;
                    nxt_cnt   = DRAIN_INIT;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) begin
                    nxt_state = ST_DONE;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
                illegal   = 1'b1;
            end
        endcase
    end

    // State, counter and sticky error registers; reset overrides everything including recovery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            err   <= err | illegal;
        end
    end

    assign busy = state[1] | state[2] | state[3];
    assign done = state[4];

endmodule

// File: tb/tb_onehot5_seq.sv
// tb/tb_onehot5_seq.sv - directed self-checking bench for onehot5_seq
module tb_onehot5_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] state0, nxt0, state1, nxt1;
    logic       busy0, done0, err0, busy1, done1, err1;

    int n_chk;
    int n_pass;
    logic exp_err;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_LOAD  = 5'b00010;
    localparam logic [4:0] S_RUN   = 5'b00100;
    localparam logic [4:0] S_DRAIN = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    onehot5_seq dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .state(state0), .nxt_state(nxt0), .busy(busy0), .done(done0), .err(err0)
    );

    onehot5_seq #(.LOAD_CYC(1), .RUN_CYC(1), .DRAIN_CYC(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .state(state1), .nxt_state(nxt1), .busy(busy1), .done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected state i cycles after the start edge; ab > 0 means abort was sampled at the end of cycle ab.
    function automatic logic [4:0] exp_st(input int i, input int ab, input int l, input int r, input int d);
        int j;
        if (i <= 0) return S_IDLE;
        if (ab > 0 && i > ab) begin
            j = i - ab;
            if (j <= d) return S_DRAIN;
            if (j == d + 1) return S_DONE;
            return S_IDLE;
        end
        if (i <= l) return S_LOAD;
        if (i <= l + r) return S_RUN;
        if (i <= l + r + d) return S_DRAIN;
        if (i == l + r + d + 1) return S_DONE;
        return S_IDLE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // One job from IDLE. ab: real abort cycle; st: ignored start cycle; ab2: ignored abort cycle; both: abort with start.
    task automatic run_job(input string tag, input int u, input int ab, input int st, input int ab2, input bit both);
        int l, r, d, last, busy_cnt;
        logic [4:0] s, n, e;
        logic b, dn, er;
        l = (u != 0) ? 1 : 3;
        r = (u != 0) ? 1 : 8;
        d = (u != 0) ? 1 : 2;
        last = (ab > 0) ? ab + d + 2 : l + r + d + 2;
        busy_cnt = 0;
        start = 1'b1;
        abort = both;
        #1;
        n = (u != 0) ? nxt1 : nxt0;
        check({tag, " nxt0"}, 32'(n), 32'(S_LOAD));
        for (int i = 1; i <= last; i++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            s  = (u != 0) ? state1 : state0;
            b  = (u != 0) ? busy1 : busy0;
            dn = (u != 0) ? done1 : done0;
            er = (u != 0) ? err1 : err0;
            e  = exp_st(i, ab, l, r, d);
            check($sformatf("%s state[%0d]", tag, i), 32'(s), 32'(e));
            check($sformatf("%s done[%0d]", tag, i), 32'(dn), 32'(e == S_DONE));
            check($sformatf("%s err[%0d]", tag, i), 32'(er), 32'(exp_err));
            if (b) busy_cnt++;
            if (i == ab) abort = 1'b1;
            if (i == st) start = 1'b1;
            if (i == ab2) abort = 1'b1;
            if (i < last) begin
                #1;
                n = (u != 0) ? nxt1 : nxt0;
                check($sformatf("%s nxt[%0d]", tag, i), 32'(n), 32'(exp_st(i + 1, ab, l, r, d)));
            end
        end
        check({tag, " busy_cycles"}, 32'(busy_cnt),
              32'((ab > 0) ? ab + d : l + r + d));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_err = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        check("rst state", 32'(state0), 32'(S_IDLE));
        check("rst busy", 32'(busy0), 32'd0);
        check("rst done", 32'(done0), 32'd0);
        check("rst err", 32'(err0), 32'd0);
        check("rst nxt", 32'(nxt0), 32'(S_IDLE));
        rst = 1'b0;
        step();

        run_job("plain", 0, 0, 0, 0, 1'b0);
        run_job("abort_run5", 0, 8, 0, 0, 1'b0);
        run_job("abort_load_last", 0, 3, 0, 0, 1'b0);
        run_job("start_abort_idle", 0, 0, 0, 0, 1'b1);

        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle state", 32'(state0), 32'(S_IDLE));
        run_job("ign_run_drain", 0, 0, 6, 12, 1'b0);
        run_job("ign_done", 0, 0, 14, 0, 1'b0);

        // Start held high: DONE goes to IDLE for one cycle, then LOAD again.
        start = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            check($sformatf("held state[%0d]", i), 32'(state0),
                  32'(exp_st(((i - 1) % 15) + 1, 0, 3, 8, 2)));
        end
        start = 1'b0;
        reset_all();

        // Illegal pattern injected for the edge after this one.
        force dut0.state = 5'b00110;
        #1;
        check("illegal nxt", 32'(nxt0), 32'(S_IDLE));
        release dut0.state;
        step();
        check("illegal recover", 32'(state0), 32'(S_IDLE));
        check("illegal err", 32'(err0), 32'd1);
        exp_err = 1'b1;
        run_job("err_sticky", 0, 0, 0, 0, 1'b0);
        reset_all();
        exp_err = 1'b0;
        check("err cleared", 32'(err0), 32'd0);

        // Reset mid-RUN with start high.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst state", 32'(state0), 32'(S_RUN));
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst state", 32'(state0), 32'(S_IDLE));
        check("mid_rst busy", 32'(busy0), 32'd0);
        check("mid_rst done", 32'(done0), 32'd0);
        run_job("after_rst", 0, 0, 0, 0, 1'b0);

        reset_all();
        run_job("short_cyc", 1, 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
